// File: rtl/seq_det_scheduler.sv
// Byte-level controller for a serial 1011 Moore detector. It clears the detector, shifts each
// word MSB-first, collects a per-bit hit mask and keeps a saturating cumulative hit count.
module seq_det_scheduler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              det_seq,
  output logic              det_clr,
  input  logic              det_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_mask,
  output logic [CNT_W-1:0]  res_count,
  input  logic              res_ready,
  input  logic              clr_count
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam int unsigned PC_W  = $clog2(DATA_W + 1);
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESULT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   final_mask;
  logic [IDX_W-1:0]    pos;
  logic                capture_done;
  logic                det_seq_d, det_clr_d, res_valid_d;
  logic [DATA_W-1:0]   res_mask_d;
  logic [CNT_W-1:0]    res_count_d;
  logic [SUM_W-1:0]    cnt_base, cnt_sum;

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  assign in_ready = (state_q == IDLE);

  // Bit shifted in SHIFT cycle k-1 is visible on det_out in cycle k.
  assign pos = IDX_W'(DATA_W - int'(idx_q));

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    final_mask   = acc_q;
    capture_done = 1'b0;
    res_valid_d  = res_valid;
    res_mask_d   = res_mask;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          idx_d   = '0;
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        if (idx_q != '0) acc_d[pos] = det_out;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DATA_W - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        final_mask   = acc_q | DATA_W'(det_out);
        acc_d        = final_mask;
        res_mask_d   = final_mask;
        res_valid_d  = 1'b1;
        capture_done = 1'b1;
        state_d      = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear coinciding with a capture clears first, then adds this word's hits
    cnt_base = clr_count ? '0 : SUM_W'(res_count);
    cnt_sum  = cnt_base + (capture_done ? SUM_W'(popcount(final_mask)) : '0);
    res_count_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(cnt_sum);

    det_seq_d = (state_d == SHIFT) && shift_d[DATA_W-1];
    det_clr_d = (state_d == IDLE) || (state_d == RESULT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      det_seq   <= 1'b0;
      det_clr   <= 1'b1;
      res_valid <= 1'b0;
      res_mask  <= '0;
      res_count <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      det_seq   <= det_seq_d;
      det_clr   <= det_clr_d;
      res_valid <= res_valid_d;
      res_mask  <= res_mask_d;
      res_count <= res_count_d;
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: two instances (wide and 2-bit counter) share stimulus, each
// driving its own behavioural 1011 detector; results are checked against a window-scan model.
module tb_seq_det_scheduler;

  logic       clock, reset;
  logic       in_valid, res_ready, clr_count;
  logic [7:0] in_data;

  logic        in_ready_l, det_seq_l, det_clr_l, det_out_l, res_valid_l;
  logic [7:0]  res_mask_l;
  logic [15:0] res_count_l;
  logic        in_ready_s, det_seq_s, det_clr_s, det_out_s, res_valid_s;
  logic [7:0]  res_mask_s;
  logic [1:0]  res_count_s;

  logic [3:0] hist_l, hist_s;
  int n_checks, n_pass;
  int exp_l, exp_s;

  seq_det_scheduler #(.DATA_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_l), .det_seq(det_seq_l), .det_clr(det_clr_l), .det_out(det_out_l),
    .res_valid(res_valid_l), .res_mask(res_mask_l), .res_count(res_count_l),
    .res_ready(res_ready), .clr_count(clr_count)
  );

  seq_det_scheduler #(.DATA_W(8), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_s), .det_seq(det_seq_s), .det_clr(det_clr_s), .det_out(det_out_s),
    .res_valid(res_valid_s), .res_mask(res_mask_s), .res_count(res_count_s),
    .res_ready(res_ready), .clr_count(clr_count)
  );

  // Detector stand-ins: Moore output is "last four sampled bits were 1011"
  always_ff @(posedge clock or posedge det_clr_l)
    if (det_clr_l) hist_l <= '0; else hist_l <= {hist_l[2:0], det_seq_l};
  always_ff @(posedge clock or posedge det_clr_s)
    if (det_clr_s) hist_s <= '0; else hist_s <= {hist_s[2:0], det_seq_s};
  assign det_out_l = (hist_l == 4'b1011);
  assign det_out_s = (hist_s == 4'b1011);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int sat_add(input int base, input int add, input int w);
    int s, mx;
    s  = base + add;
    mx = (1 << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  // Bit b set when the four bits ending at b (MSB-first order) spell 1011
  function automatic logic [7:0] ref_mask(input logic [7:0] d);
    logic [7:0] m;
    logic [7:0] sh;
    m = '0;
    for (int b = 0; b <= 4; b++) begin
      sh = d >> b;
      if (sh[3:0] == 4'b1011) m[3'(b)] = 1'b1;
    end
    return m;
  endfunction

  task automatic send_word(input logic [7:0] data, input logic [7:0] exp_mask,
                           input bit clr_cap, input int stall);
    int n, wc;
    logic [7:0]  hm;
    logic [15:0] hc;
    wc = 0;
    while (!in_ready_l && wc < 50) begin @(posedge clock); #1; wc++; end
    if (!in_ready_l) begin check("in_ready_timeout", 32'(in_ready_l), 32'(1)); return; end
    res_ready = (stall == 0);
    in_valid  = 1'b1;
    in_data   = data;
    @(posedge clock); #1;
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom);
    n = 0;
    while (!res_valid_l && n < 30) begin
      if (n == 0) check("in_ready_busy", 32'(in_ready_l), 32'(0));
      if (n < 8) begin
        check("det_seq", 32'(det_seq_l), 32'(data[3'(7 - n)]));
        check("det_clr_shift", 32'(det_clr_l), 32'(0));
      end
      if (n == 8 && clr_cap) clr_count = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    clr_count = 1'b0;
    in_valid  = 1'b0;
    exp_l = sat_add(clr_cap ? 0 : exp_l, $countones(exp_mask), 16);
    exp_s = sat_add(clr_cap ? 0 : exp_s, $countones(exp_mask), 2);
    check("latency", 32'(n), 32'(9));
    check("mask", 32'(res_mask_l), 32'(exp_mask));
    check("mask_s", 32'(res_mask_s), 32'(exp_mask));
    check("count", 32'(res_count_l), 32'(exp_l));
    check("count_s", 32'(res_count_s), 32'(exp_s));
    check("det_clr_result", 32'(det_clr_l), 32'(1));
    hm = res_mask_l;
    hc = res_count_l;
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      check("stall_valid", 32'(res_valid_l), 32'(1));
      check("stall_mask", 32'(res_mask_l), 32'(hm));
      check("stall_count", 32'(res_count_l), 32'(hc));
      check("stall_in_ready", 32'(in_ready_l), 32'(0));
      check("stall_det_clr", 32'(det_clr_l), 32'(1));
    end
    res_ready = 1'b1;
    @(posedge clock); #1;
    check("res_valid_drop", 32'(res_valid_l), 32'(0));
    check("in_ready_back", 32'(in_ready_l), 32'(1));
  endtask

  initial begin
    logic [7:0] d;
    n_checks = 0; n_pass = 0; exp_l = 0; exp_s = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b1; clr_count = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready_l), 32'(1));
    check("rst_det_clr", 32'(det_clr_l), 32'(1));
    check("rst_det_seq", 32'(det_seq_l), 32'(0));
    check("rst_res_valid", 32'(res_valid_l), 32'(0));
    check("rst_res_mask", 32'(res_mask_l), 32'(0));
    check("rst_res_count", 32'(res_count_l), 32'(0));
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // One hit per word: wide counter 1..4, 2-bit counter saturates at 3
    repeat (4) send_word(8'b1011_0000, 8'b0001_0000, 1'b0, 0);
    send_word(8'b1011_0110, 8'b0001_0010, 1'b1, 0);
    send_word(8'b1011_0110, 8'b0001_0010, 1'b0, 0);
    send_word(8'b1011_1011, 8'b0001_0001, 1'b0, 0);
    send_word(8'b0000_0001, 8'b0000_0000, 1'b0, 0);
    send_word(8'b1011_0000, 8'b0001_0000, 1'b0, 5);

    // Standalone counter clear in IDLE
    clr_count = 1'b1;
    @(posedge clock); #1;
    clr_count = 1'b0;
    exp_l = 0; exp_s = 0;
    check("clr_count", 32'(res_count_l), 32'(0));
    check("clr_count_s", 32'(res_count_s), 32'(0));
    check("clr_in_ready", 32'(in_ready_l), 32'(1));

    send_word(8'b1011_0110, 8'b0001_0010, 1'b0, 0);

    // Abort during SHIFT index 4
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'b1011_0000;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    exp_l = 0; exp_s = 0;
    check("abort_det_clr", 32'(det_clr_l), 32'(1));
    check("abort_in_ready", 32'(in_ready_l), 32'(1));
    check("abort_res_valid", 32'(res_valid_l), 32'(0));
    check("abort_count", 32'(res_count_l), 32'(0));
    repeat (3) begin
      @(posedge clock); #1;
      check("abort_no_result", 32'(res_valid_l), 32'(0));
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    send_word(8'b1011_0000, 8'b0001_0000, 1'b0, 0);

    // Randomized words against the window-scan model
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      send_word(d, ref_mask(d), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Byte-level controller that drives the team's serial 1011 Moore sequence detector.
- Accepts bytes over a valid/ready handshake and clears the detector before each byte. It shifts the byte MSB-first into the detector, captures the detector output after every bit, and returns a per-bit hit mask plus a saturating cumulative hit count over a valid/ready result handshake.
- Sits between the byte-wide stream fabric and one detector instance. Each byte is an independent detection frame.

Parameters:
- DATA_W, 8, bits per input word (must be >= 2).
- CNT_W, 16, width of the cumulative hit counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_data  input  DATA_W  word to scan, shifted MSB first.
- in_ready  output  1  block can accept a word.
- det_seq  output  1  drives the detector's serial input.
- det_clr  output  1  drives the detector's async active-high reset.
- det_out  input  1  detector Moore output (combinational from detector state).
- res_valid  output  1  result valid.
- res_mask  output  DATA_W  bit b = 1 if the detector asserted after in_data[b] was shifted.
- res_count  output  CNT_W  saturating cumulative hit total.
- res_ready  input  1  result consumer ready.
- clr_count  input  1  synchronous clear of res_count.

Behaviour:
- Reset (async, active-high): state=IDLE, shift reg=0, bit index=0, det_seq=0, det_clr=1, res_valid=0, res_mask=0, res_count=0.
- Assertion mid-operation aborts the current word. No partial result is produced and the count is not updated.
- All outputs are registered except in_ready, which is (state==IDLE).
- States: IDLE, SHIFT, CAPTURE, RESULT.
- IDLE:
  - det_clr=1, det_seq=0.
  - On in_valid && in_ready: load in_data, index=0, clear the mask accumulator, go to SHIFT. det_clr falls at the same edge.
- SHIFT (DATA_W cycles, index 0..DATA_W-1):
  - det_clr=0; det_seq = shift-reg MSB. Shift left each cycle; the detector samples det_seq at the end of the cycle.
  - In SHIFT cycle k (k>=1), det_out reflects bit k-1. Capture it into mask position DATA_W-k.
  - After index DATA_W-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - det_clr=0, det_seq=0.
  - Capture det_out into mask position 0 (the last bit). det_clr must stay low here so the async clear does not destroy det_out.
  - At the exit edge:
    - res_mask <= final mask.
    - res_count <= sat(res_count + popcount(final mask)).
    - res_valid <= 1.
    - Go to RESULT.
- RESULT:
  - det_clr=1. res_valid, res_mask and res_count are held stable until res_ready.
  - On res_valid && res_ready: res_valid <= 0, go to IDLE.
- Latency: word accepted at edge E0; res_valid rises at edge E(DATA_W+1). Minimum word-to-word period is DATA_W+3 cycles with res_ready held high.
- Counter:
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_count alone: res_count <= 0 next edge.
  - clr_count coinciding with the CAPTURE exit edge: res_count <= popcount(this mask), i.e. clear, then add.
  - clr_count has no effect on state or res_valid.
- in_data changes while not accepted are ignored. in_valid during SHIFT/CAPTURE/RESULT is not accepted (in_ready=0).
- A bit sampled by the detector during the CAPTURE cycle is discarded, because det_clr asserts in RESULT.

Test Plan:
- Reset, then in_data=8'b1011_0000 with res_ready=1 -> res_valid high exactly 9 cycles after the accept edge; res_mask=8'b0001_0000, res_count=1.
- in_data=8'b1011_0110 (overlap) -> res_mask=8'b0001_0010, res_count +2.
- in_data=8'b1011_1011 -> res_mask=8'b0001_0001. Next word 8'b0000_0001 -> res_mask=0, proving the per-word clear and no carry-over of the trailing "1".
- res_ready held low 5 cycles in RESULT -> res_valid, res_mask and res_count stable; in_ready=0; det_clr=1 throughout. Release -> in_ready=1 the next cycle.
- CNT_W=2 and four words each with 1 hit -> res_count = 1, 2, 3, 3 (saturates). clr_count pulse on the CAPTURE exit edge of a 2-hit word -> res_count=2.
- Assert reset during SHIFT index 4 -> immediate det_clr=1, in_ready=1, no res_valid pulse, res_count=0. A following word 8'b1011_0000 yields the normal result.
